// File: rtl/cache_pkg.sv
// cache_pkg: shared line geometry, AXI encodings and writeback FSM states
package cache_pkg;
  localparam int LINE_BITS = 128;
  localparam int WORD_BITS = 32;
  localparam int LINE_BYTES = 16;
  localparam int INDEX_LENGTH = 4;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B = 3'b010;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  typedef enum logic [2:0] {IDLE, CAPTURE, ADDR, DATA, RESP, DONE} wbState_e;
endpackage

// File: rtl/wb_line_buffer.sv
// wb_line_buffer: snapshot register for one cache line plus the beat counter that walks its words
// Ports: load captures lineIn and restarts at word0; advance steps to the next word;
//        word is the current word, last flags the final word of the line.
module wb_line_buffer
  import cache_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 advance,
  input  logic [LINE_BITS-1:0] lineIn,
  output logic [WORD_BITS-1:0] word,
  output logic                 last
);
  logic [LINE_BITS-1:0] line;
  logic [1:0] beat;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      line <= '0;
      beat <= '0;
    end else if (load) begin
      line <= lineIn;
      beat <= '0;
    end else if (advance) beat <= beat + 2'd1;
  assign word = line[beat*WORD_BITS +: WORD_BITS];
  assign last = &beat;
endmodule

// File: rtl/cache_line_writeback.sv
// cache_line_writeback: evicts one dirty cache line to memory as a single 4-beat AXI4 INCR write burst
// Ports: wb_req_* request handshake (tag/index of victim); ram_index/ram_rdata combinational RAM read;
//        line_captured pulses when the RAM slot may be reused; wb_done pulses at completion,
//        wb_err holds a non-OKAY response until the next accepted request; aw*/w*/b* AXI write channels.
module cache_line_writeback
  import cache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INDEX_W = INDEX_LENGTH,
  parameter int WORD_W = WORD_BITS,
  parameter int WORDS_PER_LINE = LINE_BITS / WORD_BITS,
  parameter int TAG_W = ADDR_W - INDEX_W - $clog2(LINE_BYTES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_req_valid,
  output logic                 wb_req_ready,
  input  logic [TAG_W-1:0]     wb_req_tag,
  input  logic [INDEX_W-1:0]   wb_req_index,
  output logic [INDEX_W-1:0]   ram_index,
  input  logic [LINE_BITS-1:0] ram_rdata,
  output logic                 line_captured,
  output logic                 wb_done,
  output logic                 wb_err,
  output logic                 awvalid,
  input  logic                 awready,
  output logic [ADDR_W-1:0]    awaddr,
  output logic [7:0]           awlen,
  output logic [2:0]           awsize,
  output logic [1:0]           awburst,
  output logic                 wvalid,
  input  logic                 wready,
  output logic [WORD_W-1:0]    wdata,
  output logic [3:0]           wstrb,
  output logic                 wlast,
  input  logic                 bvalid,
  output logic                 bready,
  input  logic [1:0]           bresp
);
  wbState_e state, nextState;
  logic [TAG_W-1:0] tagQ;
  logic [INDEX_W-1:0] indexQ;
  logic lastBeat;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      tagQ <= '0;
      indexQ <= '0;
      wb_err <= 1'b0;
    end else begin
      state <= nextState;
      if (wb_req_valid && wb_req_ready) begin
        tagQ <= wb_req_tag;
        indexQ <= wb_req_index;
        wb_err <= 1'b0;
      end
      if (state == RESP && bvalid) wb_err <= bresp != RESP_OKAY;
    end
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    nextState = wb_req_valid ? CAPTURE : IDLE;
      CAPTURE: nextState = ADDR;
      ADDR:    nextState = awready ? DATA : ADDR;
      DATA:    nextState = (wready && lastBeat) ? RESP : DATA;
      RESP:    nextState = bvalid ? DONE : RESP;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end
  // The line is copied out of the RAM in CAPTURE so the slot can be refilled during the burst.
  wb_line_buffer buffer (
    .clk(clk),
    .rst(rst),
    .load(state == CAPTURE),
    .advance(wvalid && wready),
    .lineIn(ram_rdata),
    .word(wdata),
    .last(lastBeat)
  );
  assign wb_req_ready = state == IDLE;
  assign line_captured = state == CAPTURE;
  assign awvalid = state == ADDR;
  assign wvalid = state == DATA;
  assign bready = state == RESP;
  assign wb_done = state == DONE;
  assign wlast = wvalid && lastBeat;
  assign wstrb = 4'hF;
  assign ram_index = indexQ;
  assign awaddr = {tagQ, indexQ, {$clog2(LINE_BYTES){1'b0}}};
  assign awlen = 8'(WORDS_PER_LINE - 1);
  assign awsize = SIZE_4B;
  assign awburst = BURST_INCR;
endmodule

// File: tb/tb_cache_line_writeback.sv
// tb_cache_line_writeback: directed scoreboard bench for the cache line writeback burst engine
module tb_cache_line_writeback;
  logic clk = 0, rst = 0;
  logic wb_req_valid, wb_req_ready, line_captured, wb_done, wb_err;
  logic [23:0] wb_req_tag;
  logic [3:0] wb_req_index, ram_index, wstrb;
  logic [127:0] ram_rdata;
  logic awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [31:0] awaddr, wdata;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst, bresp;
  typedef struct packed {logic [31:0] data; logic last;} beat_t;
  beat_t wQ[$];
  logic [31:0] awQ[$];
  logic errQ[$];
  int passCnt = 0, failCnt = 0, totalCnt = 0;

  cache_line_writeback dut (
    .clk(clk), .rst(rst),
    .wb_req_valid(wb_req_valid), .wb_req_ready(wb_req_ready),
    .wb_req_tag(wb_req_tag), .wb_req_index(wb_req_index),
    .ram_index(ram_index), .ram_rdata(ram_rdata),
    .line_captured(line_captured), .wb_done(wb_done), .wb_err(wb_err),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idleChecks(input string tag);
    chk({tag, "_ready"}, wb_req_ready, 1);
    chk({tag, "_awvalid"}, awvalid, 0);
    chk({tag, "_wvalid"}, wvalid, 0);
    chk({tag, "_wlast"}, wlast, 0);
    chk({tag, "_bready"}, bready, 0);
    chk({tag, "_captured"}, line_captured, 0);
    chk({tag, "_done"}, wb_done, 0);
    chk({tag, "_err"}, wb_err, 0);
    chk({tag, "_ram_index"}, ram_index, 0);
    chk({tag, "_awaddr"}, awaddr, 0);
  endtask

  task automatic runBurst(input logic [23:0] tag, input logic [3:0] idx, input logic [127:0] line,
                          input logic [1:0] resp, input int awDelay, input bit wToggle,
                          input bit snap, input bit busyReq, input bit rstMid, input int expWait);
    int waitCyc = 0, beats = 0, awWait = 0;
    bit done = 0, aborted = 0, sawW = 0;
    wb_req_valid = 1;
    wb_req_tag = tag;
    wb_req_index = idx;
    ram_rdata = line;
    bresp = resp;
    bvalid = 1;
    wready = 1;
    awready = awDelay == 0;
    do begin
      @(negedge clk);
      waitCyc++;
    end while (!wb_req_ready && waitCyc < 20);
    if (expWait > 0) chk("accept_wait", waitCyc, expWait);
    @(posedge clk);
    #1 wb_req_valid = 0;
    awQ.push_back({tag, idx, 4'h0});
    for (int i = 0; i < 4; i++) wQ.push_back({line[32*i +: 32], i == 3});
    errQ.push_back(resp != 2'b00);
    for (int c = 1; c <= 60 && !done && !aborted; c++) begin
      wready = wToggle ? c[0] : 1'b1;
      awready = awWait >= awDelay;
      @(negedge clk);
      if (c == 1) begin
        chk("capture_pulse", line_captured, 1);
        chk("ram_index", ram_index, idx);
        chk("err_cleared", wb_err, 0);
      end
      if (rstMid && wvalid && beats == 2) begin
        #1 rst = 1;
        #1 idleChecks("mid_rst");
        wQ.delete();
        awQ.delete();
        errQ.delete();
        aborted = 1;
        @(posedge clk);
        #1 rst = 0;
      end else begin
        if (awvalid) begin
          if (awQ.size() == 0) chk("aw_unexpected", awvalid, 0);
          else begin
            chk("awaddr", awaddr, awQ[0]);
            chk("awlen", awlen, 3);
            chk("awsize", awsize, 3'b010);
            chk("awburst", awburst, 2'b01);
            if (awready) begin
              void'(awQ.pop_front());
              if (awDelay == 0) chk("aw_latency", c, 2);
            end else awWait++;
          end
        end
        if (wvalid) begin
          sawW = 1;
          if (wQ.size() == 0) chk("w_unexpected", wvalid, 0);
          else begin
            chk("wdata", wdata, wQ[0].data);
            chk("wlast", wlast, wQ[0].last);
            chk("wstrb", wstrb, 4'hF);
            if (wready) begin
              void'(wQ.pop_front());
              beats++;
            end
          end
          if (busyReq) chk("busy_ready", wb_req_ready, 0);
        end
        if (wb_done) begin
          if (errQ.size() == 0) chk("done_unexpected", wb_done, 0);
          else chk("done_err", wb_err, errQ.pop_front());
          chk("beats", beats, 4);
          if (busyReq) chk("busy_ready_done", wb_req_ready, 0);
          if (awDelay == 0 && !wToggle) chk("done_latency", c, 8);
          done = 1;
        end
        @(posedge clk);
        #1;
        if (snap && c == 1) ram_rdata = '1;
        if (busyReq && sawW) wb_req_valid = 1;
      end
    end
    if (!done && !aborted) chk("timeout", done, 1);
  endtask

  initial begin
    wb_req_valid = 0;
    wb_req_tag = '0;
    wb_req_index = '0;
    ram_rdata = '0;
    awready = 0;
    wready = 0;
    bvalid = 0;
    bresp = 0;
    #1 rst = 1;
    #2 idleChecks("reset");
    repeat (2) @(posedge clk);
    #1 rst = 0;
    runBurst(24'hABCDEF, 4'h5, 128'h44444444_33333333_22222222_11111111, 2'b00, 0, 0, 0, 0, 0, 0);
    runBurst(24'h123456, 4'hA, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 2'b00, 3, 1, 0, 0, 0, 0);
    runBurst(24'h0F0F0F, 4'h3, 128'h01234567_89ABCDEF_FEDCBA98_76543210, 2'b00, 0, 0, 1, 0, 0, 0);
    runBurst(24'hDEAD00, 4'hF, 128'h0000000F_000000F0_00000F00_0000F000, 2'b10, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("err_held", wb_err, 1);
    runBurst(24'h000001, 4'h0, 128'h80000000_40000000_20000000_10000000, 2'b00, 0, 0, 0, 0, 0, 0);
    runBurst(24'h555555, 4'h7, 128'h5A5A5A5A_A5A5A5A5_0F0F0F0F_F0F0F0F0, 2'b00, 0, 0, 0, 0, 1, 0);
    runBurst(24'h555555, 4'h7, 128'h5A5A5A5A_A5A5A5A5_0F0F0F0F_F0F0F0F0, 2'b00, 0, 0, 0, 0, 0, 0);
    runBurst(24'h666666, 4'h1, 128'h13579BDF_2468ACE0_11223344_55667788, 2'b00, 0, 1, 0, 1, 0, 0);
    runBurst(24'h666666, 4'h1, 128'hCAFEBABE_DEADBEEF_0BADF00D_FEEDFACE, 2'b00, 0, 0, 0, 0, 0, 1);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule

// File: doc/cache_line_writeback.md
Name: cache_line_writeback

Overview:
- Evicts one dirty cache line from the data RAM to main memory as a single AXI4 write burst.
- Sits between the cache controller and the AXI write channels.
- On request it reads the 128-bit line through the RAM's combinational read port and snapshots it into a local buffer, freeing the RAM slot for refill.
- It then serialises the four words, lowest address first, and reports completion and response status.

Parameters:
- ADDR_W, 32, byte-address width on AXI.
- INDEX_W, 4, cache line index width (16 lines).
- WORD_W, 32, data word width; fixed, AXI data width.
- WORDS_PER_LINE, 4, words per line; burst length is WORDS_PER_LINE-1.
- TAG_W, ADDR_W-INDEX_W-4, tag width (16-byte lines).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- wb_req_valid  in  1  eviction request.
- wb_req_ready  out  1  high only in IDLE.
- wb_req_tag  in  TAG_W  tag of the victim line.
- wb_req_index  in  INDEX_W  index of the victim line.
- ram_index  out  INDEX_W  index driven to the data RAM read port.
- ram_rdata  in  128  line read from the data RAM; word0 is [31:0].
- line_captured  out  1  one-cycle pulse; the RAM line may now be overwritten.
- wb_done  out  1  one-cycle pulse when the burst completes.
- wb_err  out  1  set when bresp!=2'b00; held until the next request is accepted.
- awvalid  out  1  AXI AW valid.
- awready  in  1  AXI AW ready.
- awaddr  out  ADDR_W  AXI AW address.
- awlen  out  8  AXI AW burst length.
- awsize  out  3  AXI AW beat size.
- awburst  out  2  AXI AW burst type.
- wvalid  out  1  AXI W valid.
- wready  in  1  AXI W ready.
- wdata  out  WORD_W  AXI W data.
- wstrb  out  4  AXI W byte strobes.
- wlast  out  1  AXI W last beat.
- bvalid  in  1  AXI B valid.
- bready  out  1  AXI B ready.
- bresp  in  2  AXI B response.

Behaviour:
- Reset state (async): state=IDLE, buffer=0, beat counter=0, every valid/pulse output 0, wb_err=0, ram_index=0, awaddr=0.
- IDLE: wb_req_ready=1.
  - On valid&ready: latch tag and index, clear wb_err, drive ram_index=latched index, go to CAPTURE.
- CAPTURE (1 cycle): buffer<=ram_rdata; line_captured=1 this cycle; go to ADDR.
- ADDR: awvalid=1.
  - awaddr={tag,index,4'b0000}, awlen=8'd3, awsize=3'b010, awburst=2'b01 (INCR).
  - All AW fields stay stable until awready; on the handshake go to DATA with beat=0.
- DATA: wvalid=1, wdata=buffer word[beat], wstrb=4'hF, wlast=(beat==3).
  - On wvalid&wready: beat++.
  - On the handshake with beat==3: go to RESP.
  - wready low stalls; wdata is held stable.
- RESP: bready=1. On bvalid: wb_err<=(bresp!=0); go to DONE.
- DONE (1 cycle): wb_done=1; go to IDLE.
  - Next request accepted no earlier than the cycle after DONE.
- Latency with zero-wait AXI: accept→CAPTURE +1, AW handshake +2, last W +6, B +7, wb_done +8.
- Boundary cases:
  - awready held high before awvalid: handshake completes on the first ADDR cycle.
  - bvalid already high on entry to RESP: consumed that cycle.
  - wb_req_valid while busy: ignored (ready=0); it must be held by the requester.
  - rst mid-burst: all outputs return to reset values immediately; the partial burst is abandoned. The memory side is reset by the same rst.
  - ram_rdata changes after CAPTURE: no effect on the burst.

Decomposition:
- Shared cache_pkg holds:
  - LINE_BITS=128, WORD_BITS=32, LINE_BYTES=16, INDEX_LENGTH=4.
  - AXI encodings: BURST_INCR=2'b01, SIZE_4B=3'b010, RESP_OKAY=2'b00.
  - FSM state localparams IDLE/CAPTURE/ADDR/DATA/RESP/DONE.
- One natural sub-module, wb_line_buffer:
  - 128-bit capture register plus 2-bit beat counter.
  - Outputs the selected word and the last flag.

Test Plan:
- Basic burst: tag=0x0ABCDEF, index=5, ram_rdata=0x44444444_33333333_22222222_11111111, AXI always ready, bresp=0.
  - awaddr=0x0ABCDEF50, awlen=3.
  - W beats 0x11111111, 0x22222222, 0x33333333, 0x44444444.
  - wlast only on beat 4; wb_done at cycle +8; wb_err=0.
- Backpressure: awready delayed 3 cycles, wready toggled 1/0 each cycle.
  - AW fields stable while stalled, wdata stable while stalled.
  - Still exactly 4 beats in order.
- Snapshot: change ram_rdata to all-ones right after the line_captured pulse.
  - Burst still carries the original words.
- Error response: bresp=2'b10 → wb_err=1 with wb_done.
  - The next accepted request clears wb_err.
- Mid-burst reset: assert rst during beat 2.
  - wvalid/awvalid/bready drop asynchronously and state returns to IDLE.
  - A new request then completes normally.
- Busy request: assert wb_req_valid during DATA.
  - wb_req_ready=0 until after DONE.
  - Held request accepted the cycle after wb_done.
